// File: rtl/branch_redirect_if.sv
// Bundle between execute/fetch and the branch redirect unit.
// master = redirect unit side, slave = pipeline side that drives the inputs.
interface branch_redirect_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              ex_done;
  logic              ex_jump;
  logic [ADDR_W-1:0] ex_target;
  logic [ADDR_W-1:0] ex_pc;
  logic              fetch_busy;
  logic              redirect_ready;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              flush_front;
  logic              hold_execute;
  logic              misalign_trap;
  logic [ADDR_W-1:0] trap_pc;
  logic [CNT_W-1:0]  redirect_count;

  modport master (
    input  ex_done, ex_jump, ex_target, ex_pc, fetch_busy, redirect_ready,
    output redirect_valid, redirect_pc, flush_front, hold_execute,
           misalign_trap, trap_pc, redirect_count
  );

  modport slave (
    output ex_done, ex_jump, ex_target, ex_pc, fetch_busy, redirect_ready,
    input  redirect_valid, redirect_pc, flush_front, hold_execute,
           misalign_trap, trap_pc, redirect_count
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Turns a resolved jump from execute into a front-end flush plus a fetch redirect,
// or a misaligned-target trap. Every output is a register decoded from the next state.
module branch_redirect_unit #(
  parameter int ADDR_W     = 64,
  parameter int ALIGN_BITS = 2,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  branch_redirect_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_FETCH,
    REDIRECT,
    TRAP
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] target_q, target_next;
  logic [ADDR_W-1:0] trap_pc_q, trap_pc_next;
  logic [CNT_W-1:0]  count_q, count_next;
  logic              valid_q, flush_q, hold_q, trap_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              misaligned;

  assign misaligned = (bus.ex_target[ALIGN_BITS-1:0] != '0);

  // Next-state logic; a new jump is only looked at while IDLE, so nothing queues.
  always_comb begin
    state_next   = state;
    target_next  = target_q;
    trap_pc_next = trap_pc_q;
    count_next   = count_q;
    case (state)
      IDLE: begin
        if (bus.ex_done && bus.ex_jump) begin
          target_next = bus.ex_target;
          if (misaligned) begin
            trap_pc_next = bus.ex_pc;
            state_next   = TRAP;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH:      state_next = bus.fetch_busy ? WAIT_FETCH : REDIRECT;
      WAIT_FETCH: if (!bus.fetch_busy) state_next = REDIRECT;
      REDIRECT: begin
        if (bus.redirect_ready) begin
          count_next = count_q + CNT_W'(1);
          state_next = IDLE;
        end
      end
      TRAP:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      target_q      <= '0;
      trap_pc_q     <= '0;
      count_q       <= '0;
      valid_q       <= 1'b0;
      flush_q       <= 1'b0;
      hold_q        <= 1'b0;
      trap_q        <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state         <= state_next;
      target_q      <= target_next;
      trap_pc_q     <= trap_pc_next;
      count_q       <= count_next;
      valid_q       <= (state_next == REDIRECT);
      flush_q       <= (state_next == FLUSH) || (state_next == TRAP);
      hold_q        <= (state_next != IDLE);
      trap_q        <= (state_next == TRAP);
      redirect_pc_q <= (state_next == REDIRECT) ? target_next : '0;
    end
  end

  assign bus.redirect_valid = valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush_front    = flush_q;
  assign bus.hold_execute   = hold_q;
  assign bus.misalign_trap  = trap_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.redirect_count = count_q;

endmodule
